// File: rtl/pipe_md_pkg.sv
// ============================================================================
//  Module      : pipe_md_pkg
//  Description : Shared encodings for the EXE-stage multiply/divide sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package pipe_md_pkg;

   localparam int MD_ITER = 32;

   // EXE_md_op encodings
   localparam logic [1:0] MD_MULT  = 2'b00;
   localparam logic [1:0] MD_MULTU = 2'b01;
   localparam logic [1:0] MD_DIV   = 2'b10;
   localparam logic [1:0] MD_DIVU  = 2'b11;

   // sequencer states
   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] RUN  = 2'b01;
   localparam logic [1:0] DONE = 2'b10;

endpackage

`default_nettype wire

// File: rtl/md_iter_core.sv
// ============================================================================
//  Module      : md_iter_core
//  Description : One-bit-per-cycle shift-add multiply / restoring divide step.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module md_iter_core #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             load,
   input  logic             step,
   input  logic             is_div,
   input  logic [WIDTH-1:0] init_lo,
   input  logic [WIDTH-1:0] init_opnd,
   output logic [WIDTH-1:0] nxt_hi,
   output logic [WIDTH-1:0] nxt_lo
);

   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_low;
   logic [WIDTH-1:0] r_opnd;

   logic [WIDTH-1:0] w_src_acc;
   logic [WIDTH-1:0] w_src_low;
   logic [WIDTH-1:0] w_opnd;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_part;
   logic [WIDTH+1:0] w_diff;

   // A load also performs the first step, so the start cycle does useful work.
   assign w_src_acc = load ? '0        : r_acc;
   assign w_src_low = load ? init_lo   : r_low;
   assign w_opnd    = load ? init_opnd : r_opnd;

   assign w_sum  = {1'b0, w_src_acc} + (w_src_low[0] ? {1'b0, w_opnd} : '0);
   assign w_part = {w_src_acc, w_src_low[WIDTH-1]};
   assign w_diff = {1'b0, w_part} - {2'b00, w_opnd};

   always_comb begin
      nxt_hi = '0;
      nxt_lo = '0;
      if (is_div) begin
         if (w_diff[WIDTH+1]) begin
            nxt_hi = w_part[WIDTH-1:0];
            nxt_lo = {w_src_low[WIDTH-2:0], 1'b0};
         end else begin
            nxt_hi = w_diff[WIDTH-1:0];
            nxt_lo = {w_src_low[WIDTH-2:0], 1'b1};
         end
      end else begin
         nxt_hi = w_sum[WIDTH:1];
         nxt_lo = {w_sum[0], w_src_low[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_acc  <= '0;
         r_low  <= '0;
         r_opnd <= '0;
      end else if (load || step) begin
         r_acc  <= nxt_hi;
         r_low  <= nxt_lo;
         r_opnd <= w_opnd;
      end
   end

endmodule

`default_nettype wire

// File: rtl/pipe_exe_muldiv_ctrl.sv
// ============================================================================
//  Module      : pipe_exe_muldiv_ctrl
//  Description : EXE-stage mul/div sequencer owning HI/LO, with pipeline stall.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_exe_muldiv_ctrl
   import pipe_md_pkg::*;
#(
   parameter int WIDTH = MD_ITER,
   parameter int CNT_W = 5
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             EXE_md_start,
   input  logic [1:0]       EXE_md_op,
   input  logic [WIDTH-1:0] EXE_a,
   input  logic [WIDTH-1:0] EXE_b,
   input  logic             EXE_hi_we,
   input  logic             EXE_lo_we,
   input  logic [WIDTH-1:0] EXE_wdata,
   input  logic             EXE_flush,
   output logic             md_stall,
   output logic             md_done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic             r_is_div;
   logic             r_neg_res;
   logic             r_neg_rem;
   logic             r_b_zero;
   logic [WIDTH-1:0] r_a_orig;

   logic             w_signed;
   logic             w_op_div;
   logic             w_start;
   logic             w_last;
   logic             w_mt_ok;
   logic [WIDTH-1:0] w_abs_a;
   logic [WIDTH-1:0] w_abs_b;
   logic [WIDTH-1:0] w_core_hi;
   logic [WIDTH-1:0] w_core_lo;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0] w_quot;
   logic [WIDTH-1:0] w_rem;
   logic [WIDTH-1:0] w_res_hi;
   logic [WIDTH-1:0] w_res_lo;

   assign w_signed = (EXE_md_op == MD_MULT) || (EXE_md_op == MD_DIV);
   assign w_op_div = (EXE_md_op == MD_DIV)  || (EXE_md_op == MD_DIVU);
   assign w_abs_a  = (w_signed && EXE_a[WIDTH-1]) ? -EXE_a : EXE_a;
   assign w_abs_b  = (w_signed && EXE_b[WIDTH-1]) ? -EXE_b : EXE_b;

   assign w_start  = (r_state != RUN) && EXE_md_start && !EXE_flush;
   assign w_last   = (r_state == RUN) && (r_cnt == CNT_W'(WIDTH-1)) && !EXE_flush;
   assign w_mt_ok  = (r_state != RUN) && !EXE_md_start && !EXE_flush;

   assign md_stall = (r_state == RUN) || w_start;
   assign md_done  = (r_state == DONE);
   assign hi       = r_hi;
   assign lo       = r_lo;

   md_iter_core #(
      .WIDTH     (WIDTH)
   ) u_core (
      .clock     (clock),
      .resetn    (resetn),
      .load      (w_start),
      .step      ((r_state == RUN) && !EXE_flush),
      .is_div    (w_start ? w_op_div : r_is_div),
      .init_lo   (w_abs_a),
      .init_opnd (w_abs_b),
      .nxt_hi    (w_core_hi),
      .nxt_lo    (w_core_lo)
   );

   // Sign fix-up on the final step's combinational result.
   assign w_prod = r_neg_res ? -{w_core_hi, w_core_lo} : {w_core_hi, w_core_lo};
   assign w_quot = r_neg_res ? -w_core_lo : w_core_lo;
   assign w_rem  = r_neg_rem ? -w_core_hi : w_core_hi;

   always_comb begin
      w_res_hi = w_prod[2*WIDTH-1:WIDTH];
      w_res_lo = w_prod[WIDTH-1:0];
      if (r_is_div) begin
         if (r_b_zero) begin
            w_res_hi = r_a_orig;
            w_res_lo = '1;
         end else begin
            w_res_hi = w_rem;
            w_res_lo = w_quot;
         end
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_is_div  <= 1'b0;
         r_neg_res <= 1'b0;
         r_neg_rem <= 1'b0;
         r_b_zero  <= 1'b0;
         r_a_orig  <= '0;
      end else begin
         case (r_state)
            RUN: begin
               r_cnt <= r_cnt + CNT_W'(1);
               if (EXE_flush) begin
                  r_state <= IDLE;
               end else if (w_last) begin
                  r_state <= DONE;
                  r_hi    <= w_res_hi;
                  r_lo    <= w_res_lo;
               end
            end
            default: begin
               if (w_start) begin
                  // The start edge already completed step one.
                  r_state   <= RUN;
                  r_cnt     <= CNT_W'(1);
                  r_is_div  <= w_op_div;
                  r_neg_res <= w_signed && (EXE_a[WIDTH-1] ^ EXE_b[WIDTH-1]);
                  r_neg_rem <= w_signed && EXE_a[WIDTH-1];
                  r_b_zero  <= (EXE_b == '0);
                  r_a_orig  <= EXE_a;
               end else begin
                  r_state <= IDLE;
                  if (w_mt_ok && EXE_hi_we) r_hi <= EXE_wdata;
                  if (w_mt_ok && EXE_lo_we) r_lo <= EXE_wdata;
               end
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_pipe_exe_muldiv_ctrl.sv
// ============================================================================
//  Module      : tb_pipe_exe_muldiv_ctrl
//  Description : Directed self-checking bench for the mul/div sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_exe_muldiv_ctrl;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   logic        clock;
   logic        resetn;
   logic        EXE_md_start;
   logic [1:0]  EXE_md_op;
   logic [31:0] EXE_a;
   logic [31:0] EXE_b;
   logic        EXE_hi_we;
   logic        EXE_lo_we;
   logic [31:0] EXE_wdata;
   logic        EXE_flush;
   logic        md_stall;
   logic        md_done;
   logic [31:0] hi;
   logic [31:0] lo;

   int total = 0;
   int bad   = 0;

   pipe_exe_muldiv_ctrl #(
      .WIDTH        (32),
      .CNT_W        (5)
   ) dut (
      .clock        (clock),
      .resetn       (resetn),
      .EXE_md_start (EXE_md_start),
      .EXE_md_op    (EXE_md_op),
      .EXE_a        (EXE_a),
      .EXE_b        (EXE_b),
      .EXE_hi_we    (EXE_hi_we),
      .EXE_lo_we    (EXE_lo_we),
      .EXE_wdata    (EXE_wdata),
      .EXE_flush    (EXE_flush),
      .md_stall     (md_stall),
      .md_done      (md_done),
      .hi           (hi),
      .lo           (lo)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      EXE_md_op    = op;
      EXE_a        = a;
      EXE_b        = b;
      EXE_md_start = 1'b1;
   endtask

   // Counts stalled cycles until the DONE cycle, then checks the result there.
   task automatic wait_result(input string tag, input int exp_n,
                              input logic [31:0] eh, input logic [31:0] el);
      int n;
      n = 0;
      forever begin
         @(negedge clock);
         if (!md_stall || n >= 100) break;
         n++;
         @(posedge clock);
         #1 EXE_md_start = 1'b0;
      end
      chk({tag, " stall_cycles"}, 32'(n), 32'(exp_n));
      chk({tag, " md_done"}, {31'd0, md_done}, 32'd1);
      chk({tag, " hi"}, hi, eh);
      chk({tag, " lo"}, lo, el);
   endtask

   initial begin
      int seen;
      resetn       = 1'b0;
      EXE_md_start = 1'b0;
      EXE_md_op    = OP_MULT;
      EXE_a        = '0;
      EXE_b        = '0;
      EXE_hi_we    = 1'b0;
      EXE_lo_we    = 1'b0;
      EXE_wdata    = '0;
      EXE_flush    = 1'b0;

      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("reset stall", {31'd0, md_stall}, 32'd0);
      chk("reset done",  {31'd0, md_done},  32'd0);
      chk("reset hi", hi, 32'h0);
      chk("reset lo", lo, 32'h0);
      resetn = 1'b1;
      @(posedge clock); #1;

      // MULT 7 * -3 = -21
      start_op(OP_MULT, 32'd7, 32'hFFFF_FFFD);
      wait_result("mult", 32, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      @(negedge clock);
      chk("mult done_pulse_one_cycle", {31'd0, md_done}, 32'd0);
      @(posedge clock); #1;

      // DIVU 100/7, then DIV -7/2 issued in the DONE cycle
      start_op(OP_DIVU, 32'd100, 32'd7);
      wait_result("divu", 32, 32'd2, 32'd14);
      #1 start_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
      #1;
      chk("b2b stall_in_done", {31'd0, md_stall}, 32'd1);
      chk("b2b done_in_done",  {31'd0, md_done},  32'd1);
      wait_result("div_neg", 31, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      @(posedge clock); #1;

      start_op(OP_DIV, 32'h1234_5678, 32'd0);
      wait_result("div_by_zero", 32, 32'h1234_5678, 32'hFFFF_FFFF);
      @(posedge clock); #1;

      start_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_result("multu_max", 32, 32'hFFFF_FFFE, 32'h0000_0001);
      @(posedge clock); #1;

      start_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_result("div_ovf", 32, 32'h0, 32'h8000_0000);
      @(posedge clock); #1;

      // MTHI during RUN is ignored; 0x10000 * 0x10000 = 1 << 32
      start_op(OP_MULT, 32'h0001_0000, 32'h0001_0000);
      @(negedge clock);
      @(posedge clock); #1;
      EXE_md_start = 1'b0;
      EXE_hi_we    = 1'b1;
      EXE_wdata    = 32'hDEAD_BEEF;
      @(posedge clock); #1;
      EXE_hi_we    = 1'b0;
      wait_result("mthi_in_run", 30, 32'h1, 32'h0);
      @(posedge clock); #1;

      // MTLO while IDLE
      EXE_lo_we = 1'b1;
      EXE_wdata = 32'hCAFE_F00D;
      @(negedge clock);
      chk("mtlo before_edge", lo, 32'h0);
      @(posedge clock); #1;
      EXE_lo_we = 1'b0;
      chk("mtlo lo", lo, 32'hCAFE_F00D);
      chk("mtlo hi_kept", hi, 32'h1);

      // Start + MTLO in one cycle (write dropped), then flush at iteration 10
      start_op(OP_MULT, 32'd5, 32'd6);
      EXE_lo_we = 1'b1;
      EXE_wdata = 32'h1111_1111;
      @(posedge clock); #1;
      EXE_md_start = 1'b0;
      EXE_lo_we    = 1'b0;
      repeat (8) @(posedge clock);
      #1 EXE_flush = 1'b1;
      @(negedge clock);
      chk("flush stall_during_run", {31'd0, md_stall}, 32'd1);
      @(posedge clock); #1;
      EXE_flush = 1'b0;
      @(negedge clock);
      chk("flush stall_dropped", {31'd0, md_stall}, 32'd0);
      chk("flush no_done", {31'd0, md_done}, 32'd0);
      chk("flush hi_kept", hi, 32'h1);
      chk("flush lo_kept", lo, 32'hCAFE_F00D);
      seen = 0;
      repeat (40) begin
         @(negedge clock);
         if (md_done) seen++;
      end
      chk("flush never_done", 32'(seen), 32'd0);

      // Flush in IDLE suppresses a start
      @(posedge clock); #1;
      start_op(OP_MULTU, 32'd2, 32'd2);
      EXE_flush = 1'b1;
      #1 chk("idle_flush stall", {31'd0, md_stall}, 32'd0);
      @(posedge clock); #1;
      EXE_md_start = 1'b0;
      EXE_flush    = 1'b0;
      @(negedge clock);
      chk("idle_flush stays_idle", {31'd0, md_stall}, 32'd0);

      // Reset in the middle of a DIVU
      @(posedge clock); #1;
      start_op(OP_DIVU, 32'd1000, 32'd3);
      @(posedge clock); #1;
      EXE_md_start = 1'b0;
      repeat (19) @(posedge clock);
      #3 resetn = 1'b0;
      #1;
      chk("midrun_reset hi", hi, 32'h0);
      chk("midrun_reset lo", lo, 32'h0);
      chk("midrun_reset stall", {31'd0, md_stall}, 32'd0);
      chk("midrun_reset done",  {31'd0, md_done},  32'd0);
      @(negedge clock);
      resetn = 1'b1;
      @(posedge clock); #1;
      start_op(OP_MULTU, 32'd3, 32'd4);
      wait_result("post_reset_multu", 32, 32'h0, 32'd12);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
